// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit blocks: parity modes,
// receiver state encoding and a counter-width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = cnt_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_next = rd_ptr_q + 1'b1;
  assign head    = head_q;
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_next;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // The head register tracks whatever word will be at the read pointer next cycle.
      if (push_ok && (empty || (pop_ok && count_q == CW'(1)))) head_q <= push_data;
      else if (pop_ok && count_q > CW'(1))                     head_q <= mem_q[rd_next];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, error detection and a receive FIFO
// exposing a ready/valid read side.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int              CNT_W     = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            ODD_MODE  = (PARITY == PAR_ODD);

  logic                 rxd_meta_q;
  logic                 rxd_s_q;
  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 stop_bad_q;
  logic                 par_bad_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 overrun_q;
  logic                 bit_tick;
  logic                 final_stop;
  logic                 push_d;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign bit_tick   = (cnt_q == LAST_CNT);
  assign final_stop = (state_q == ST_STOP) && bit_tick && (stop_idx_q == STOP_LAST);
  // The word enters the FIFO in the very cycle its last stop bit is sampled.
  assign push_d     = final_stop && rxd_s_q && !stop_bad_q && !par_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      stop_bad_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= push_d & fifo_full & ~rx_ready;
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          stop_bad_q <= 1'b0;
          par_bad_q  <= 1'b0;
          if (!rxd_s_q) state_q <= ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q   <= '0;
            state_q <= rxd_s_q ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else                       bit_idx_q <= bit_idx_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_bad_q <= ((^shift_q) ^ rxd_s_q) != ODD_MODE;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (stop_idx_q == STOP_LAST) begin
              if (!rxd_s_q || stop_bad_q) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_WAIT_IDLE;
              end else begin
                parity_err_q <= par_bad_q;
                state_q      <= ST_IDLE;
              end
            end else begin
              stop_bad_q <= stop_bad_q | ~rxd_s_q;
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rxd_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_d),
    .push_data(shift_q),
    .full     (fifo_full),
    .pop      (rx_ready),
    .head     (rx_data),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rx_valid   = ~fifo_empty;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are built from field values, the
// expected outcome of each frame is queued up front and a monitor checks pops and pulses.
module tb_uart_rx_fifo;

  localparam int CLKS  = 13;
  localparam int DBITS = 8;
  localparam int PAR   = 2;
  localparam int SBITS = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rxd = 1'b1;
  logic             rx_ready = 1'b0;
  logic [DBITS-1:0] rx_data;
  logic             rx_valid;
  logic [CW-1:0]    fifo_count;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  int nChecks = 0;
  int nPassed = 0;
  logic [DBITS-1:0] sb[$];
  int expFrameErr = 0, expParityErr = 0, expOverrun = 0;
  int gotFrameErr = 0, gotParityErr = 0, gotOverrun = 0;
  int validCycles = 0;
  int readyMode = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CLKS),
    .DATA_BITS   (DBITS),
    .PARITY      (PAR),
    .STOP_BITS   (SBITS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Consumer: held low, held high, or randomly toggling each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: tallies error pulses and checks every accepted word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  gotFrameErr++;
      if (parity_err) gotParityErr++;
      if (overrun)    gotOverrun++;
      if (rx_valid)   validCycles++;
      if (rx_valid && rx_ready) begin
        if (sb.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected_pop: got word 0x%0h, expected no word", rx_data);
        end else begin
          checkOutput("rx_data", 32'(rx_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic waitBits(input int n);
    repeat (n * CLKS) @(negedge clk);
  endtask

  // One frame on rxd; the outcome follows directly from the framing rules.
  task automatic applyStimulus(input logic [DBITS-1:0] data, input bit badPar,
                               input logic [1:0] badStop, input int lowHold, input int gapBits);
    logic pbit;
    pbit = (PAR == 2) ? ^data : ~^data;
    if (badPar) pbit = ~pbit;
    if (badStop != 2'b00)       expFrameErr++;
    else if (badPar)            expParityErr++;
    else if (sb.size() >= DEPTH) expOverrun++;
    else                        sb.push_back(data);
    @(negedge clk);
    rxd = 1'b0;
    waitBits(1);
    for (int i = 0; i < DBITS; i++) begin
      rxd = data[i];
      waitBits(1);
    end
    if (PAR != 0) begin
      rxd = pbit;
      waitBits(1);
    end
    for (int s = 0; s < SBITS; s++) begin
      rxd = ~badStop[s];
      waitBits(1);
    end
    if (lowHold > 0) begin
      rxd = 1'b0;
      repeat (lowHold) @(negedge clk);
    end
    rxd = 1'b1;
    waitBits(gapBits);
    checkOutput("frame_err_count", 32'(gotFrameErr), 32'(expFrameErr));
    checkOutput("parity_err_count", 32'(gotParityErr), 32'(expParityErr));
    checkOutput("overrun_count", 32'(gotOverrun), 32'(expOverrun));
  endtask

  task automatic waitDrain(input string name);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    checkOutput(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    checkOutput({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    checkOutput({tag, "_errs"}, {29'd0, frame_err, parity_err, overrun}, 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no completion, expected finish within 90000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (4) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word with an always-ready consumer is visible for exactly one cycle.
    readyMode = 1;
    validCycles = 0;
    applyStimulus(8'h01, 1'b0, 2'b00, 0, 2);
    waitDrain("drain_single");
    checkOutput("valid_cycles_single", 32'(validCycles), 32'd1);

    // Glitch shorter than half a bit is ignored, next frame arrives intact.
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    waitBits(2);
    checkOutput("false_start_count", 32'(fifo_count), 32'd0);
    applyStimulus(8'h5A, 1'b0, 2'b00, 0, 2);
    waitDrain("drain_false_start");

    // Last stop bit low with a stuck-low line, then recovery.
    applyStimulus(8'h55, 1'b0, 2'b10, 120, 2);
    applyStimulus(8'hA5, 1'b0, 2'b00, 0, 2);
    // First stop bit low only.
    applyStimulus(8'hC3, 1'b0, 2'b01, 0, 2);
    waitDrain("drain_frame_err");

    // Parity error, parity error combined with stop error, then good word.
    applyStimulus(8'h41, 1'b1, 2'b00, 0, 2);
    applyStimulus(8'h42, 1'b1, 2'b10, 0, 2);
    applyStimulus(8'h41, 1'b0, 2'b00, 0, 2);
    waitDrain("drain_parity");

    // Stalled consumer: fill the FIFO, overflow once, then drain in order.
    readyMode = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < DEPTH + 1; k++) applyStimulus(8'(8'h10 + k), 1'b0, 2'b00, 0, 1);
    checkOutput("count_when_full", 32'(fifo_count), 32'(DEPTH));
    checkOutput("valid_when_full", 32'(rx_valid), 32'd1);
    checkOutput("head_when_full", 32'(rx_data), 32'(sb[0]));
    readyMode = 1;
    waitDrain("drain_burst");
    checkOutput("valid_after_drain", 32'(rx_valid), 32'd0);
    checkOutput("count_after_drain", 32'(fifo_count), 32'd0);

    // Randomised traffic with a randomly stalling consumer.
    readyMode = 2;
    for (int k = 0; k < 25; k++) begin
      logic [DBITS-1:0] d;
      bit bp;
      logic [1:0] bs;
      d  = DBITS'($urandom);
      bp = ($urandom_range(0, 4) == 0);
      bs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(d, bp, bs, 0, 1 + $urandom_range(0, 2));
    end
    readyMode = 1;
    waitDrain("drain_random");

    // Reset in the middle of data bit 3 of an all-ones word abandons it.
    @(negedge clk);
    rxd = 1'b0;
    waitBits(1);
    rxd = 1'b1;
    waitBits(3);
    repeat (CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    waitBits(2);
    readyMode = 0;
    repeat (3) @(negedge clk);
    applyStimulus(8'h3C, 1'b0, 2'b00, 0, 2);
    checkOutput("count_after_reset_frame", 32'(fifo_count), 32'd1);
    checkOutput("head_after_reset_frame", 32'(rx_data), 32'h3C);
    readyMode = 1;
    waitDrain("drain_after_reset");

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. Adds configurable data width, parity, stop bits and bit timing. Adds framing, parity and overrun detection, plus a receive FIFO with a ready/valid read side. Sits between the board rxd pin and any byte consumer (echo logic, command parser).

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit period (>= 4)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  FIFO head word, valid only when rx_valid=1
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts; pop when rx_valid & rx_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy
frame_err  output  1  one-cycle pulse: a stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch
overrun  output  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
- Reset (async assert, sync release):
  - Synchroniser flops = 1; state = IDLE; counters = 0; FIFO empty.
  - rx_valid, rx_data, fifo_count, frame_err, parity_err, overrun = 0.
  - Reset mid-frame abandons the frame; nothing is pushed.
- rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s.
- Sample timing:
  - HALF = CLKS_PER_BIT/2 (integer division).
  - d = first cycle IDLE sees rxd_s=0.
  - Start check at d+HALF.
  - Data bit i (0-based) at d+HALF+(i+1)*CLKS_PER_BIT.
  - Parity bit, if enabled, follows the last data bit by one bit period; stop bit(s) follow in turn, one period each.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE -> START on rxd_s=0.
  - START: rxd_s=1 at the check means false start -> IDLE, no flags. rxd_s=0 -> DATA.
  - DATA: shift DATA_BITS samples, LSB first. Then -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: compare sample with the computed bit. Odd parity: data XOR parity bit = 1. Even parity: = 0.
  - STOP: sample each stop bit.
    - Any stop bit = 0: frame_err pulse, discard the word, -> WAIT_IDLE.
    - Otherwise, if a parity mismatch was recorded: parity_err pulse, discard, -> IDLE.
    - Otherwise: push the word, -> IDLE.
    - Pulse and push occur in the cycle of the final stop sample.
  - WAIT_IDLE: stay until rxd_s=1 (break / stuck-low line), then -> IDLE.
  - frame_err takes precedence over parity_err; only one pulse per frame.
- FIFO:
  - Synchronous and first-word-fall-through.
  - rx_valid rises the cycle after the push; rx_data is registered head.
  - Push when full and no pop in the same cycle: word dropped, overrun pulse, contents unchanged.
  - Push and pop in the same cycle when full: both accepted, count unchanged, no overrun.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is updated the cycle after push/pop.
- rx_data holds its last value when the FIFO is empty; do not rely on it when rx_valid=0.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - FSM state typedef/encoding.
  - Helper function for counter width ($clog2 wrapper).
- One sub-module: uart_sync_fifo (WIDTH, DEPTH). Ports: push/push_data/full, pop/head/empty/count. Reused later by the TX path.
- Synchroniser, bit timer and FSM stay in uart_rx_fifo.

Test Plan:
1. Defaults, rx_ready=1. Stimulus: rxd low 434 cycles, high 434, low 7*434, then high. Response: one word 0x01; rx_valid high for exactly 1 cycle, one cycle after the stop sample; no error pulses.
2. Defaults. Stimulus: rxd low 100 cycles, then high. Response: no push, no error pulse, FSM back in IDLE; a following 0x5A frame is received as 0x5A.
3. Defaults. Stimulus: frame 0x55 with the stop bit driven low, line held low 2000 cycles, then frame 0xA5. Response: one frame_err pulse, 0x55 not stored, exactly one word 0xA5 received.
4. FIFO_DEPTH=4, rx_ready=0. Stimulus: frames 0x10..0x14. Response: fifo_count=4, one overrun pulse on 0x14; then rx_ready=1 pops 0x10,0x11,0x12,0x13 and rx_valid falls.
5. DATA_BITS=7, PARITY=2. Stimulus: 0x41 with parity bit 1 (wrong), then 0x41 with parity bit 0. Response: one parity_err pulse, then a single word 0x41.
6. Defaults. Stimulus: rst_n low for 3 cycles during data bit 3 of frame 0xFF, then full frame 0x3C. Response: all outputs 0 during reset, nothing pushed for 0xFF, 0x3C received, fifo_count=1 with rx_ready=0.
